freq_meter: RTL and testbench

//   Measures the frequency of a slow, asynchronous square-wave input by counting
//   its rising edges over a fixed gate window of clk_in cycles. This is the inverse of
//   the clock divider: it turns a toggling signal back into a number. With the default

---
 rtl/freq_meter.sv | 133 +++++++++++++
 tb/tb_freq_meter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous square wave over a fixed
// gate of GATE_CYCLES clk_in cycles. With GATE_CYCLES equal to the clk_in
// frequency the result reads directly in Hz.
//
// Handshake: meas_valid is a 1-cycle pulse with no ready; meas_count and
// overflow change only in the cycle meas_valid is high and hold until the next
// pulse. There is no backpressure, so a consumer must sample on the pulse.
//
// dbg_state exposes the FSM state (0=IDLE, 1=GATE, 2=DONE) for checkers.
module freq_meter #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int GATE_CYCLES = CLK_FREQ_HZ,
    parameter int CNT_W       = 27,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             overflow,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int              GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t                 state;
    state_t                 next_state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_d;
    logic                   edge_pulse;
    logic [GW-1:0]          gate_cnt;
    logic [CNT_W-1:0]       edge_cnt;
    logic                   sat_flag;

    assign dbg_state  = state;
    // One pulse per rising edge of the synchronized input.
    assign edge_pulse = sync_ff[SYNC_STAGES-1] & ~sync_d;

    // Synchronizer chain on sig_in followed by the edge-detect register.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_ff <= '0;
            sync_d  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], sig_in};
            sync_d  <= sync_ff[SYNC_STAGES-1];
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: dropping enable inside a gate aborts it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (enable) next_state = GATE;
            end
            GATE: begin
                if (!enable)                   next_state = IDLE;
                else if (gate_cnt == GATE_LAST) next_state = DONE;
            end
            DONE: begin
                next_state = enable ? GATE : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Gate/edge counters and registered result outputs.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat_flag   <= 1'b0;
            meas_count <= '0;
            meas_valid <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            busy       <= (next_state == GATE) || (next_state == DONE);
            case (state)
                GATE: begin
                    if (!enable) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat_flag <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GW'(1);
                        if (edge_pulse) begin
                            if (edge_cnt == CNT_MAX) sat_flag <= 1'b1;
                            else                     edge_cnt <= edge_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Edges seen in this cycle are intentionally dropped.
                    meas_count <= edge_cnt;
                    overflow   <= sat_flag;
                    meas_valid <= 1'b1;
                    gate_cnt   <= '0;
                    edge_cnt   <= '0;
                    sat_flag   <= 1'b0;
                end
                default: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: drives freq_meter (GATE_CYCLES=1000) with periodic and held
// inputs. A second instance with CNT_W=8 shares all inputs to exercise counter
// saturation. Expected counts are queued when a measurement is started and
// compared when meas_valid pulses.
module tb_freq_meter;

    localparam int GATE = 1000;

    // ---------------- clock / reset / DUT ----------------
    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic        sig_in;
    logic        enable = 1'b0;
    logic [26:0] meas_count;
    logic        meas_valid, overflow, busy;
    logic [1:0]  dbg_state;
    logic [7:0]  meas_count8;
    logic        meas_valid8, overflow8, busy8;
    logic [1:0]  dbg_state8;

    always #5 clk_in = ~clk_in;

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(27), .SYNC_STAGES(2)) dut (
        .clk_in(clk_in), .reset(reset), .sig_in(sig_in), .enable(enable),
        .meas_count(meas_count), .meas_valid(meas_valid), .overflow(overflow),
        .busy(busy), .dbg_state(dbg_state)
    );

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk_in(clk_in), .reset(reset), .sig_in(sig_in), .enable(enable),
        .meas_count(meas_count8), .meas_valid(meas_valid8), .overflow(overflow8),
        .busy(busy8), .dbg_state(dbg_state8)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_valid = 0;
    int last_valid_cyc = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // ---------------- stimulus generator ----------------
    // half > 0: sig_in toggles every 'half' cycles (period 2*half).
    // half == 0: sig_in holds hold_level.
    int   half = 0;
    logic hold_level = 1'b0;

    initial begin
        int ph;
        ph = 0;
        sig_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (half > 0) begin
                if (ph >= half - 1) begin
                    sig_in = ~sig_in;
                    ph = 0;
                end else begin
                    ph++;
                end
            end else begin
                sig_in = hold_level;
                ph = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    // A steady periodic input with period P yields exactly 1000/P edges in any
    // 1000-cycle window, so steady-state gates carry a tolerance of 0.
    logic [26:0] exp_q[$];
    int          tol_q[$];
    logic [26:0] last_exp = '0;
    logic [26:0] mon_e;
    logic [7:0]  mon_e8;
    int          mon_t, mon_d;

    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (meas_valid || meas_valid8) begin
                n_tests++;
                if (meas_valid8 !== meas_valid) begin
                    n_fail++;
                    $display("FAIL valid_match: got %0b (cnt8) vs %0b, required equal", meas_valid8, meas_valid);
                end
            end
            if (meas_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: got meas_valid=1 at cycle %0d, required none", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_t = tol_q.pop_front();
                    last_exp = mon_e;
                    mon_e8 = (mon_e > 27'd255) ? 8'd255 : mon_e[7:0];
                    mon_d = int'(meas_count) - int'(mon_e);
                    if (mon_d < 0) mon_d = -mon_d;
                    if (mon_d > mon_t) begin
                        n_fail++;
                        $display("FAIL meas_count: got %0d required %0d (+/-%0d)", meas_count, mon_e, mon_t);
                    end
                    n_tests++;
                    mon_d = int'(meas_count8) - int'(mon_e8);
                    if (mon_d < 0) mon_d = -mon_d;
                    if (mon_d > mon_t) begin
                        n_fail++;
                        $display("FAIL meas_count8: got %0d required %0d (+/-%0d)", meas_count8, mon_e8, mon_t);
                    end
                    n_tests++;
                    if (overflow !== 1'b0) begin
                        n_fail++;
                        $display("FAIL overflow: got %0b required 0", overflow);
                    end
                    n_tests++;
                    if (overflow8 !== (mon_e > 27'd255)) begin
                        n_fail++;
                        $display("FAIL overflow8: got %0b required %0b", overflow8, (mon_e > 27'd255));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_valids(input int target, input int budget, output bit ok);
        int k;
        k = 0;
        while (k < budget && n_valid < target) begin
            @(negedge clk_in);
            k++;
        end
        ok = (n_valid >= target);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Start a measurement at a negedge; returns the cycle count at that point.
    task automatic start_meas(output int en_cyc);
        @(negedge clk_in);
        enable = 1'b1;
        en_cyc = cyc;
    endtask

    task automatic stop_meas();
        @(negedge clk_in);
        enable = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        wait_cycles(3);
        n_tests++;
        if (meas_count !== '0 || meas_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cnt=%0d v=%0b ovf=%0b busy=%0b required all 0",
                     meas_count, meas_valid, overflow, busy);
        end
        n_tests++;
        if (dbg_state !== 2'd0 || dbg_state8 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d/%0d required 0", dbg_state, dbg_state8);
        end
        @(negedge clk_in);
        reset = 1'b1;
        wait_cycles(5);
        n_tests++;
        if (busy !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_hold: got busy=%0b state=%0d required 0/0", busy, dbg_state);
        end
    endtask

    task automatic test_period10();
        int en_cyc, base;
        bit ok;
        half = 5;
        wait_cycles(50);
        base = n_valid;
        exp_q.push_back(27'd100); tol_q.push_back(0);
        start_meas(en_cyc);
        wait_valids(base + 1, 1100, ok);
        stop_meas();
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL p10_timeout: got %0d valids required %0d", n_valid - base, 1);
        end
        n_tests++;
        if (last_valid_cyc != en_cyc + GATE + 2) begin
            n_fail++;
            $display("FAIL p10_latency: got %0d cycles required %0d", last_valid_cyc - en_cyc, GATE + 2);
        end
        wait_cycles(3);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL p10_busy_after_stop: got %0b required 0", busy);
        end
    endtask

    task automatic test_hold();
        int en_cyc, base;
        bit ok;
        for (int lvl = 0; lvl < 2; lvl++) begin
            half = 0;
            hold_level = (lvl == 1);
            wait_cycles(10);
            base = n_valid;
            exp_q.push_back(27'd0); tol_q.push_back(0);
            start_meas(en_cyc);
            n_tests++;
            @(posedge clk_in); #1;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_busy: got %0b required 1 (level %0d)", busy, lvl);
            end
            wait_valids(base + 1, 1100, ok);
            stop_meas();
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL hold_timeout: got 0 valids required 1 (level %0d)", lvl);
            end
        end
    endtask

    task automatic test_fast();
        int en_cyc, base;
        bit ok;
        half = 1;
        wait_cycles(20);
        base = n_valid;
        exp_q.push_back(27'd500); tol_q.push_back(0);
        start_meas(en_cyc);
        wait_valids(base + 1, 1100, ok);
        stop_meas();
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fast_timeout: got 0 valids required 1");
        end
    endtask

    task automatic test_back_to_back();
        int en_cyc, base, c1, c2, c3;
        bit ok1, ok2, ok3;
        half = 5;
        wait_cycles(20);
        base = n_valid;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(27'd100); tol_q.push_back(0);
        end
        start_meas(en_cyc);
        wait_valids(base + 1, 1100, ok1); c1 = last_valid_cyc;
        wait_valids(base + 2, 1100, ok2); c2 = last_valid_cyc;
        wait_valids(base + 3, 1100, ok3); c3 = last_valid_cyc;
        stop_meas();
        n_tests++;
        if (!(ok1 && ok2 && ok3)) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d valids required 3", n_valid - base);
        end
        n_tests++;
        if (c2 - c1 != GATE + 1 || c3 - c2 != GATE + 1) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d,%0d required %0d", c2 - c1, c3 - c2, GATE + 1);
        end
    endtask

    task automatic test_abort();
        int en_cyc, base;
        half = 5;
        base = n_valid;
        start_meas(en_cyc);
        // GATE entered at the next edge; 501 more edges puts gate_cnt at 500.
        wait_cycles(501);
        enable = 1'b0;
        @(posedge clk_in); #1;
        n_tests++;
        if (busy !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL abort_busy: got busy=%0b state=%0d required 0/0", busy, dbg_state);
        end
        n_tests++;
        if (meas_count !== last_exp) begin
            n_fail++;
            $display("FAIL abort_count_hold: got %0d required %0d", meas_count, last_exp);
        end
        wait_cycles(1100);
        n_tests++;
        if (n_valid != base) begin
            n_fail++;
            $display("FAIL abort_no_valid: got %0d valids required 0", n_valid - base);
        end
        n_tests++;
        if (meas_count !== last_exp || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_result_stable: got %0d/%0b required %0d/0", meas_count, overflow, last_exp);
        end
    endtask

    task automatic test_reset_mid_gate();
        int en_cyc, base, rel_cyc;
        bit ok;
        half = 5;
        start_meas(en_cyc);
        wait_cycles(600);
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (meas_count !== '0 || meas_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0 ||
            meas_count8 !== '0 || overflow8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got cnt=%0d ovf=%0b busy=%0b cnt8=%0d required all 0",
                     meas_count, overflow, busy, meas_count8);
        end
        n_tests++;
        if (dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset_state: got %0d required 0", dbg_state);
        end
        wait_cycles(3);
        base = n_valid;
        // The synchronizer restarts from 0, so one extra edge is tolerated here.
        exp_q.push_back(27'd100); tol_q.push_back(1);
        reset = 1'b1;
        rel_cyc = cyc;
        wait_valids(base + 1, 1100, ok);
        stop_meas();
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL post_reset_timeout: got 0 valids required 1");
        end
        n_tests++;
        if (last_valid_cyc != rel_cyc + GATE + 2) begin
            n_fail++;
            $display("FAIL post_reset_latency: got %0d cycles required %0d", last_valid_cyc - rel_cyc, GATE + 2);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_period10();
        test_hold();
        test_fast();
        test_back_to_back();
        test_abort();
        test_reset_mid_gate();
        wait_cycles(5);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by cycle %0d, required finish", cyc);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
